// File: rtl/multicycle_control_if.sv
// multicycle_control_if
// Bundles the instruction fields, ALU flag and memory handshake coming from
// the multi-cycle datapath together with every control line the sequencer
// drives back into it.
//   master : the control sequencer (consumes IR fields, zero, mem_ready;
//            drives strobes, mux selects, aluctl, status pulses, state)
//   slave  : the datapath / memory side (the mirror image)
// Memory handshake: memread/memwrite act as the request valid and, together
// with iord, stay stable from entry into FETCH/MEMACC until the cycle in which
// mem_ready=1 is sampled; that cycle completes the access. mem_ready is
// ignored while no strobe is raised, and no access exists without a strobe.
interface multicycle_control_if #(
  parameter int OPW     = 6,
  parameter int ALUCTLW = 4
);
  logic [OPW-1:0]     opcode;
  logic [5:0]         funct;
  logic               zero;
  logic               mem_ready;
  logic               pc_write;
  logic [1:0]         pc_src;
  logic               ir_write;
  logic               iord;
  logic               memread;
  logic               memwrite;
  logic               memtoreg;
  logic               regdst;
  logic               regwrite;
  logic               alusrc_a;
  logic [1:0]         alusrc_b;
  logic [ALUCTLW-1:0] aluctl;
  logic               branch_eq;
  logic               branch_ne;
  logic               instr_done;
  logic               illegal_op;
  logic               mem_timeout;
  logic [2:0]         state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, pc_src, ir_write, iord, memread, memwrite, memtoreg,
           regdst, regwrite, alusrc_a, alusrc_b, aluctl, branch_eq,
           branch_ne, instr_done, illegal_op, mem_timeout, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, pc_src, ir_write, iord, memread, memwrite, memtoreg,
           regdst, regwrite, alusrc_a, alusrc_b, aluctl, branch_eq,
           branch_ne, instr_done, illegal_op, mem_timeout, state
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control
// Control sequencer for the shared-ALU, single-memory MIPS core. Every
// instruction walks FETCH -> DECODE -> EXEC [-> MEMACC] [-> WB]; memory
// waits in FETCH/MEMACC are bounded by TIMEOUT cycles (0 = unbounded).
// Ports:
//   clk  : core clock, rising edge
//   rst  : asynchronous, active-high; forces FETCH and holds every output 0
//   bus  : multicycle_control_if.master (IR fields, zero, mem handshake in;
//          datapath controls, status pulses and debug state out)
module multicycle_control #(
  parameter int OPW     = 6,
  parameter int ALUCTLW = 4,
  parameter int TIMEOUT = 16
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEMACC = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b000011;
  localparam logic [5:0] OP_SW   = 6'b001011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SUBI = 6'b111000;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_ADD  = 6'b100010;
  localparam logic [5:0] OP_J    = 6'b010010;

  // A zero TIMEOUT still needs a one-bit counter to keep the RTL legal.
  localparam int CNTW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t             state_q, state_d;
  logic [OPW-1:0]     op_q;
  logic [5:0]         funct_q;
  logic [CNTW-1:0]    wait_q;
  logic [5:0]         op_now, op_lat;
  logic               legal;
  logic               waiting;
  logic               timed_out;
  logic [ALUCTLW-1:0] alu_dec;
  logic               unused_bits;

  assign op_now      = bus.opcode[5:0];
  assign op_lat      = op_q[5:0];
  assign unused_bits = ^{op_q, funct_q};
  assign bus.state   = state_q;

  // A memory wait is any FETCH/MEMACC cycle without mem_ready; the limit only
  // fires when the access is still outstanding, so a late ready still wins.
  assign waiting   = ((state_q == FETCH) || (state_q == MEMACC)) && !bus.mem_ready;
  assign timed_out = (TIMEOUT != 0) && waiting && (wait_q == CNTW'(TIMEOUT));

  always_comb begin
    legal = 1'b0;
    case (op_now)
      OP_LW, OP_SW, OP_ADDI, OP_SUBI,
      OP_BEQ, OP_BNE, OP_ADD, OP_J: legal = 1'b1;
      default:                      legal = 1'b0;
    endcase
  end

  // ALU operation class lives in the top two opcode bits of the latched IR.
  always_comb begin
    alu_dec = '0;
    case (op_lat[5:4])
      2'b00:   alu_dec = ALUCTLW'(2);
      2'b01:   alu_dec = '0;
      2'b10:   alu_dec = funct_q[ALUCTLW-1:0];
      default: alu_dec = ALUCTLW'(6);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      op_q    <= '0;
      funct_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        op_q    <= bus.opcode;
        funct_q <= bus.funct;
      end
      // A FETCH timeout re-enters FETCH, so it must clear explicitly.
      if (timed_out || (state_d != state_q)) wait_q <= '0;
      else if (waiting)                      wait_q <= wait_q + CNTW'(1);
    end
  end

  always_comb begin
    state_d         = state_q;
    bus.pc_write    = 1'b0;
    bus.pc_src      = 2'b00;
    bus.ir_write    = 1'b0;
    bus.iord        = 1'b0;
    bus.memread     = 1'b0;
    bus.memwrite    = 1'b0;
    bus.memtoreg    = 1'b0;
    bus.regdst      = 1'b0;
    bus.regwrite    = 1'b0;
    bus.alusrc_a    = 1'b0;
    bus.alusrc_b    = 2'b00;
    bus.aluctl      = '0;
    bus.branch_eq   = 1'b0;
    bus.branch_ne   = 1'b0;
    bus.instr_done  = 1'b0;
    bus.illegal_op  = 1'b0;
    bus.mem_timeout = 1'b0;
    // Reset is combinationally folded in so nothing leaks out while rst is high.
    if (!rst) begin
      case (state_q)
        FETCH: begin
          bus.aluctl   = ALUCTLW'(2);
          bus.alusrc_b = 2'b01;
          if (timed_out) begin
            bus.mem_timeout = 1'b1;
          end else begin
            bus.memread  = 1'b1;
            bus.ir_write = bus.mem_ready;
            bus.pc_write = bus.mem_ready;
            if (bus.mem_ready) state_d = DECODE;
          end
        end
        DECODE: begin
          bus.aluctl   = ALUCTLW'(2);
          bus.alusrc_b = 2'b11;
          if (legal) begin
            state_d = EXEC;
          end else begin
            bus.illegal_op = 1'b1;
            state_d        = FETCH;
          end
        end
        EXEC: begin
          bus.aluctl   = alu_dec;
          bus.alusrc_a = 1'b1;
          case (op_lat)
            OP_LW, OP_SW: begin
              bus.alusrc_b = 2'b10;
              state_d      = MEMACC;
            end
            OP_ADDI, OP_SUBI: begin
              bus.alusrc_b = 2'b10;
              state_d      = WB;
            end
            OP_ADD: state_d = WB;
            OP_BEQ: begin
              bus.branch_eq  = 1'b1;
              bus.pc_src     = 2'b01;
              bus.pc_write   = bus.zero;
              bus.instr_done = 1'b1;
              state_d        = FETCH;
            end
            OP_BNE: begin
              bus.branch_ne  = 1'b1;
              bus.pc_src     = 2'b01;
              bus.pc_write   = !bus.zero;
              bus.instr_done = 1'b1;
              state_d        = FETCH;
            end
            OP_J: begin
              bus.pc_src     = 2'b10;
              bus.pc_write   = 1'b1;
              bus.instr_done = 1'b1;
              state_d        = FETCH;
            end
            default: state_d = FETCH;
          endcase
        end
        MEMACC: begin
          bus.aluctl = alu_dec;
          bus.iord   = 1'b1;
          if (timed_out) begin
            bus.mem_timeout = 1'b1;
            state_d         = FETCH;
          end else begin
            bus.memread  = (op_lat == OP_LW);
            bus.memwrite = (op_lat == OP_SW);
            if (bus.mem_ready) begin
              if (op_lat == OP_LW) begin
                state_d = WB;
              end else begin
                bus.instr_done = 1'b1;
                state_d        = FETCH;
              end
            end
          end
        end
        WB: begin
          bus.aluctl     = alu_dec;
          bus.regwrite   = 1'b1;
          bus.regdst     = (op_lat == OP_ADD);
          bus.memtoreg   = (op_lat == OP_LW);
          bus.instr_done = 1'b1;
          state_d        = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Cycle-accurate bench for multicycle_control with TIMEOUT=4. Each scenario
// pushes the per-cycle stimulus and the expected control word for that cycle
// into paired queues; the scenario task then steps the clock, pops and compares.
module tb_multicycle_control;

  localparam int TMO = 4;

  localparam logic [5:0] OP_LW   = 6'b000011;
  localparam logic [5:0] OP_SW   = 6'b001011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SUBI = 6'b111000;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_ADD  = 6'b100010;
  localparam logic [5:0] OP_J    = 6'b010010;

  typedef struct packed {
    logic [2:0] state;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrc_a;
    logic [1:0] alusrc_b;
    logic [3:0] aluctl;
    logic       branch_eq;
    logic       branch_ne;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_timeout;
  } obs_t;

  localparam int W = $bits(obs_t);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] exp_q[$];
  logic [13:0]  stim_q[$];
  int           checks = 0;
  int           errors = 0;

  multicycle_control_if #(.OPW(6), .ALUCTLW(4)) bus ();

  multicycle_control #(.OPW(6), .ALUCTLW(4), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- expected-word builders ----------------
  function automatic obs_t sample();
    obs_t o;
    o.state = bus.state;       o.pc_write = bus.pc_write;   o.pc_src = bus.pc_src;
    o.ir_write = bus.ir_write; o.iord = bus.iord;           o.memread = bus.memread;
    o.memwrite = bus.memwrite; o.memtoreg = bus.memtoreg;   o.regdst = bus.regdst;
    o.regwrite = bus.regwrite; o.alusrc_a = bus.alusrc_a;   o.alusrc_b = bus.alusrc_b;
    o.aluctl = bus.aluctl;     o.branch_eq = bus.branch_eq; o.branch_ne = bus.branch_ne;
    o.instr_done = bus.instr_done; o.illegal_op = bus.illegal_op;
    o.mem_timeout = bus.mem_timeout;
    return o;
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_ADDI) || (op == OP_SUBI) ||
           (op == OP_BEQ) || (op == OP_BNE) || (op == OP_ADD) || (op == OP_J);
  endfunction

  function automatic logic [3:0] exp_alu(input logic [5:0] op, input logic [5:0] fn);
    if (op == OP_LW || op == OP_SW || op == OP_ADDI) return 4'd2;
    if (op == OP_SUBI || op == OP_BEQ || op == OP_BNE) return 4'd6;
    if (op == OP_ADD) return fn[3:0];
    return 4'd0;
  endfunction

  function automatic obs_t e_fetch(input logic rdy);
    obs_t e = '0;
    e.memread = 1'b1; e.alusrc_b = 2'b01; e.aluctl = 4'd2;
    e.ir_write = rdy; e.pc_write = rdy;
    return e;
  endfunction

  function automatic obs_t e_decode(input logic ill);
    obs_t e = '0;
    e.state = 3'd1; e.alusrc_b = 2'b11; e.aluctl = 4'd2; e.illegal_op = ill;
    return e;
  endfunction

  function automatic obs_t e_exec(input logic [5:0] op, input logic [5:0] fn, input logic z);
    obs_t e = '0;
    e.state = 3'd2; e.alusrc_a = 1'b1; e.aluctl = exp_alu(op, fn);
    if (op == OP_LW || op == OP_SW || op == OP_ADDI || op == OP_SUBI) e.alusrc_b = 2'b10;
    if (op == OP_BEQ) begin e.branch_eq = 1; e.pc_src = 2'b01; e.pc_write = z;  e.instr_done = 1; end
    if (op == OP_BNE) begin e.branch_ne = 1; e.pc_src = 2'b01; e.pc_write = !z; e.instr_done = 1; end
    if (op == OP_J)   begin e.pc_src = 2'b10; e.pc_write = 1; e.instr_done = 1; end
    return e;
  endfunction

  function automatic obs_t e_mem(input logic [5:0] op, input logic rdy);
    obs_t e = '0;
    e.state = 3'd3; e.iord = 1'b1; e.aluctl = exp_alu(op, 6'd0);
    e.memread = (op == OP_LW); e.memwrite = (op == OP_SW);
    e.instr_done = rdy && (op == OP_SW);
    return e;
  endfunction

  function automatic obs_t e_wb(input logic [5:0] op, input logic [5:0] fn);
    obs_t e = '0;
    e.state = 3'd4; e.regwrite = 1'b1; e.regdst = (op == OP_ADD);
    e.memtoreg = (op == OP_LW); e.aluctl = exp_alu(op, fn); e.instr_done = 1'b1;
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_cyc(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input logic rdy, input obs_t e);
    stim_q.push_back({op, fn, z, rdy});
    exp_q.push_back(e);
  endtask

  // One instruction: fw/mw wait cycles before mem_ready in FETCH/MEMACC.
  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fw, input int mw);
    for (int i = 0; i < fw; i++) push_cyc(op, fn, z, 1'b0, e_fetch(1'b0));
    push_cyc(op, fn, z, 1'b1, e_fetch(1'b1));
    if (!is_legal(op)) begin
      push_cyc(op, fn, z, 1'($urandom_range(0, 1)), e_decode(1'b1));
      return;
    end
    push_cyc(op, fn, z, 1'($urandom_range(0, 1)), e_decode(1'b0));
    push_cyc(op, fn, z, 1'($urandom_range(0, 1)), e_exec(op, fn, z));
    if (op == OP_LW || op == OP_SW) begin
      for (int i = 0; i < mw; i++) push_cyc(op, fn, z, 1'b0, e_mem(op, 1'b0));
      push_cyc(op, fn, z, 1'b1, e_mem(op, 1'b1));
    end
    if (op == OP_LW || op == OP_ADD || op == OP_ADDI || op == OP_SUBI)
      push_cyc(op, fn, z, 1'($urandom_range(0, 1)), e_wb(op, fn));
  endtask

  // Applies the next stimulus word, samples at the falling edge, returns to posedge+1.
  task automatic step(output obs_t got, output obs_t want);
    logic [13:0] s;
    s = stim_q.pop_front();
    bus.opcode = s[13:8]; bus.funct = s[7:2]; bus.zero = s[1]; bus.mem_ready = s[0];
    @(negedge clk);
    got  = sample();
    want = obs_t'(exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    obs_t got;
    bus.opcode = OP_ADD; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      got = sample();
      checks++;
      if (got !== obs_t'('0)) begin
        errors++; $display("FAIL reset_outputs got=%h want=0", got);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_add();
    obs_t got, want; int n = 0;
    push_instr(OP_ADD, 6'b100010, 1'b0, 0, 0);
    push_instr(OP_ADD, 6'b000111, 1'b1, 1, 0);
    while (exp_q.size() > 0) begin
      step(got, want); n++; checks++;
      if (got !== want) begin errors++; $display("FAIL add cyc%0d got=%h want=%h", n, got, want); end
    end
  endtask

  task automatic test_lw_wait();
    obs_t got, want; int n = 0;
    push_instr(OP_LW, 6'd0, 1'b0, 0, 2);
    push_instr(OP_LW, 6'd0, 1'b0, 2, 0);
    while (exp_q.size() > 0) begin
      step(got, want); n++; checks++;
      if (got !== want) begin errors++; $display("FAIL lw_wait cyc%0d got=%h want=%h", n, got, want); end
    end
  endtask

  task automatic test_branch();
    obs_t got, want; int n = 0;
    push_instr(OP_BEQ, 6'd0, 1'b1, 0, 0);
    push_instr(OP_BEQ, 6'd0, 1'b0, 0, 0);
    push_instr(OP_BNE, 6'd0, 1'b1, 0, 0);
    push_instr(OP_BNE, 6'd0, 1'b0, 0, 0);
    push_instr(OP_J,   6'd0, 1'b0, 0, 0);
    while (exp_q.size() > 0) begin
      step(got, want); n++; checks++;
      if (got !== want) begin errors++; $display("FAIL branch cyc%0d got=%h want=%h", n, got, want); end
    end
  endtask

  task automatic test_imm_store();
    obs_t got, want; int n = 0;
    push_instr(OP_ADDI, 6'd0, 1'b0, 0, 0);
    push_instr(OP_SUBI, 6'd0, 1'b0, 0, 0);
    push_instr(OP_SW,   6'd0, 1'b0, 0, 0);
    push_instr(OP_SW,   6'd0, 1'b0, 0, 1);
    while (exp_q.size() > 0) begin
      step(got, want); n++; checks++;
      if (got !== want) begin errors++; $display("FAIL imm_store cyc%0d got=%h want=%h", n, got, want); end
    end
  endtask

  task automatic test_illegal();
    obs_t got, want; int n = 0;
    push_instr(6'b111111, 6'd0, 1'b0, 0, 0);
    push_instr(6'b000000, 6'd0, 1'b0, 0, 0);
    push_instr(OP_ADD, 6'b100010, 1'b0, 0, 0);
    while (exp_q.size() > 0) begin
      step(got, want); n++; checks++;
      if (got !== want) begin errors++; $display("FAIL illegal cyc%0d got=%h want=%h", n, got, want); end
    end
  endtask

  task automatic test_timeout();
    obs_t got, want, t; int n = 0;
    // sw with mem_ready stuck low: TMO strobed MEMACC cycles, then the timeout cycle.
    push_cyc(OP_SW, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
    push_cyc(OP_SW, 6'd0, 1'b0, 1'b0, e_decode(1'b0));
    push_cyc(OP_SW, 6'd0, 1'b0, 1'b0, e_exec(OP_SW, 6'd0, 1'b0));
    for (int i = 0; i < TMO; i++) push_cyc(OP_SW, 6'd0, 1'b0, 1'b0, e_mem(OP_SW, 1'b0));
    t = e_mem(OP_SW, 1'b0); t.memwrite = 1'b0; t.mem_timeout = 1'b1;
    push_cyc(OP_SW, 6'd0, 1'b0, 1'b0, t);
    // Ready on the 4th MEMACC cycle, then ready exactly at the limit cycle.
    push_instr(OP_SW, 6'd0, 1'b0, 0, TMO - 1);
    push_instr(OP_LW, 6'd0, 1'b0, 0, TMO);
    // FETCH timeout stays in FETCH with a fresh count.
    for (int i = 0; i < TMO; i++) push_cyc(OP_J, 6'd0, 1'b0, 1'b0, e_fetch(1'b0));
    t = e_fetch(1'b0); t.memread = 1'b0; t.mem_timeout = 1'b1;
    push_cyc(OP_J, 6'd0, 1'b0, 1'b0, t);
    push_instr(OP_J, 6'd0, 1'b0, TMO, 0);
    while (exp_q.size() > 0) begin
      step(got, want); n++; checks++;
      if (got !== want) begin errors++; $display("FAIL timeout cyc%0d got=%h want=%h", n, got, want); end
    end
  endtask

  task automatic test_reset_mid_memacc();
    obs_t got, want; int n = 0;
    push_cyc(OP_SW, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
    push_cyc(OP_SW, 6'd0, 1'b0, 1'b0, e_decode(1'b0));
    push_cyc(OP_SW, 6'd0, 1'b0, 1'b0, e_exec(OP_SW, 6'd0, 1'b0));
    push_cyc(OP_SW, 6'd0, 1'b0, 1'b0, e_mem(OP_SW, 1'b0));
    while (exp_q.size() > 0) begin
      step(got, want); n++; checks++;
      if (got !== want) begin errors++; $display("FAIL rst_mid cyc%0d got=%h want=%h", n, got, want); end
    end
    checks++;
    if (bus.memwrite !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre memwrite got=%b want=1", bus.memwrite);
    end
    rst = 1'b1;
    #1;
    got = sample(); checks++;
    if (got !== obs_t'('0)) begin errors++; $display("FAIL rst_mid_async got=%h want=0", got); end
    @(negedge clk);
    got = sample(); checks++;
    if (got !== obs_t'('0)) begin errors++; $display("FAIL rst_mid_hold got=%h want=0", got); end
    @(posedge clk); #1;
    rst = 1'b0;
    push_instr(OP_SW, 6'd0, 1'b0, 0, 0);
    while (exp_q.size() > 0) begin
      step(got, want); n++; checks++;
      if (got !== want) begin errors++; $display("FAIL rst_refetch cyc%0d got=%h want=%h", n, got, want); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, want; int n = 0;
    logic [5:0] ops [8] = '{OP_LW, OP_SW, OP_ADDI, OP_SUBI, OP_BEQ, OP_BNE, OP_ADD, OP_J};
    logic [5:0] bad [3] = '{6'b000000, 6'b111111, 6'b101010};
    logic [5:0] op;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) op = bad[$urandom_range(0, 2)];
      else                            op = ops[$urandom_range(0, 7)];
      push_instr(op, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, TMO), $urandom_range(0, TMO));
    end
    while (exp_q.size() > 0) begin
      step(got, want); n++; checks++;
      if (got !== want) begin errors++; $display("FAIL b2b cyc%0d got=%h want=%h", n, got, want); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_imm_store();
    test_illegal();
    test_timeout();
    test_reset_mid_memacc();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
